pipelined_addsub: RTL and testbench
===================================

// Module: pipelined_addsub
// PURPOSE
//   Parametrised, pipelined two's-complement add/subtract unit for the ALU datapath.
//   Operands are split into STAGES equal chunks, and the carry is registered between chunks.
//   Valid/ready handshakes on input and output with full back-pressure.
//   Status outputs: carry-out, signed overflow, zero.
//   Successor to the combinational 32-bit adders; usable where timing forbids a full-width carry path.
// PARAMETERS
//   WIDTH   32  operand/result width in bits; must be divisible by STAGES
//   STAGES  4   pipeline register stages = latency; 1..WIDTH; CHUNK = WIDTH/STAGES bits/stage
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      a/b/cin/sub valid this cycle
//   in_ready   out  1      unit accepts an operation this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (add mode only)
//   sub        in   1      0: a+b+cin; 1: a-b (= a+~b+1, cin ignored)
//   out_valid  out  1      result outputs valid
//   out_ready  in   1      consumer takes the result this cycle
//   sum        out  WIDTH  result
//   cout       out  1      carry out of MSB (sub: 1 = no borrow)
//   overflow   out  1      signed overflow = carry into MSB ^ carry out of MSB
//   zero       out  1      sum == 0
// BEHAVIOUR
//   - Transfer: in on in_valid&&in_ready at a rising edge; out on out_valid&&out_ready.
//   - Effective operands:
//     - b_eff = sub ? ~b : b
//     - c0 = sub ? 1 : cin
//   - Stage k (1..STAGES) holds:
//     - valid_k
//     - the finished low k*CHUNK sum bits
//     - the registered carry out of chunk k-1
//     - the still-unprocessed upper bits of a and b_eff
//     - the zero-so-far flag
//   - Chunk 0 is computed combinationally from the inputs into stage 1.
//   - Chunk k is computed from stage k into stage k+1.
//   - Stage STAGES drives sum/cout/overflow/zero/out_valid directly; there is no output logic after the register.
//   - Latency: out_valid rises exactly STAGES cycles after the accepting edge when unstalled.
//   - Throughput: one operation per cycle.
//   - Per-stage ready chain:
//     - ready_STAGES = out_ready || !valid_STAGES
//     - ready_k = ready_(k+1) || !valid_k
//     - in_ready = ready_1 && !rst
//   - Bubbles collapse: an empty stage accepts while downstream is stalled.
//   - A stage whose valid=1 and ready=0 holds all of its contents unchanged.
//   - Results leave in acceptance order; no operation is dropped or duplicated.
//   - Simultaneous output pop and input push while the pipe is full is legal: full rate is sustained.
//   - Outputs while out_valid=0 are don't-care for the consumer but must not be X after reset.
//   - Reset (synchronous, rst=1 at an edge):
//     - all valid_k <= 0
//     - out_valid=0, sum=0, cout=0, overflow=0, zero=0
//     - in-flight operations are discarded
//     - in_ready=0 while rst=1; it is 1 on the first cycle after rst deasserts
//   - Width rules:
//     - sum is WIDTH bits; bits beyond the MSB are lost, except as cout.
//     - overflow is computed on the effective operation (e.g. a-b uses ~b).
//   - STAGES=1: a single registered full-width add, with latency 1.
// TESTING (WIDTH=32, STAGES=4 unless noted)
//   - Add overflow: a=7FFFFFFF, b=1, cin=0, sub=0 -> sum=80000000, cout=0, ovf=1, zero=0.
//     - out_valid exactly 4 cycles after acceptance.
//   - Negative wrap: a=80000000, b=FFFFFFFF, sub=0 -> sum=7FFFFFFF, cout=1, ovf=1.
//     - Also a=0000FFFF, b=FFFF0001 -> sum=0, cout=1, zero=1.
//   - Subtract: a=5, b=7, sub=1, cin=1 (ignored) -> FFFFFFFE, cout=0, ovf=0.
//     - Also a=80000000, b=1, sub=1 -> 7FFFFFFF, cout=1, ovf=1.
//   - Back-pressure: 8 back-to-back random ops; hold out_ready=0 for 3 cycles mid-stream.
//     - All 8 results emerge in order and match the golden model.
//     - in_ready drops only once the pipe is full.
//   - Bubble collapse: ops issued with gaps while out_ready=0 -> pipe fills to 4 entries.
//     - in_ready=0 afterwards; draining yields correct ordered results.
//   - Reset mid-op: assert rst with 3 ops in flight.
//     - out_valid=0 and all flags 0 the next cycle; no stale result appears after release.
//     - Repeat the random-op check with STAGES=1 and STAGES=8.

Source files
------------

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - chunked carry-pipelined add/subtract with valid/ready back-pressure
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int CHUNK = WIDTH / STAGES;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [STAGES-1:0] zero_q, zero_d;
    logic [STAGES-1:0] ovf_q, ovf_d;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];

    logic [STAGES-1:0] ready;
    logic              full;
    logic [WIDTH-1:0]  b_eff;
    logic              c0;

    logic              src_v, src_c, src_z, c_out;
    logic [WIDTH-1:0]  src_a, src_b, src_sum, nsum;
    logic [CHUNK-1:0]  part;
    int                p;

    assign b_eff    = sub ? ~b : b;
    assign c0       = sub ? 1'b1 : cin;
    assign in_ready = ready[0] && !rst;

    // A stage can take new data if the consumer pops or any stage at or after it is empty.
    always_comb begin
        full  = 1'b1;
        ready = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            full     = full & valid_q[s];
            ready[s] = out_ready || !full;
        end
    end

    always_comb begin
        valid_d = valid_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        sum_d   = sum_q;
        a_d     = a_q;
        b_d     = b_q;
        src_v   = 1'b0;
        src_c   = 1'b0;
        src_z   = 1'b0;
        src_a   = '0;
        src_b   = '0;
        src_sum = '0;
        nsum    = '0;
        part    = '0;
        c_out   = 1'b0;
        p       = 0;
        for (int s = 0; s < STAGES; s++) begin
            p = (s == 0) ? 0 : s - 1;
            if (s == 0) begin
                src_v   = in_valid && in_ready;
                src_a   = a;
                src_b   = b_eff;
                src_c   = c0;
                src_z   = 1'b1;
                src_sum = '0;
            end else begin
                src_v   = valid_q[p];
                src_a   = a_q[p];
                src_b   = b_q[p];
                src_c   = carry_q[p];
                src_z   = zero_q[p];
                src_sum = sum_q[p];
            end
            {c_out, part} = {1'b0, src_a[s*CHUNK +: CHUNK]} + {1'b0, src_b[s*CHUNK +: CHUNK]}
                          + {{CHUNK{1'b0}}, src_c};
            nsum                   = src_sum;
            nsum[s*CHUNK +: CHUNK] = part;
            if (ready[s]) begin
                valid_d[s] = src_v;
            end
            if (ready[s] && src_v) begin
                sum_d[s]   = nsum;
                carry_d[s] = c_out;
                a_d[s]     = src_a;
                b_d[s]     = src_b;
                zero_d[s]  = src_z && (part == '0);
                // Carry into the MSB is recovered from a^b^sum; only meaningful in the chunk holding the MSB.
                ovf_d[s]   = src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ nsum[WIDTH-1] ^ c_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            zero_q  <= '0;
            ovf_q   <= '0;
            for (int s = 0; s < STAGES; s++) begin
                sum_q[s] <= '0;
                a_q[s]   <= '0;
                b_q[s]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            for (int s = 0; s < STAGES; s++) begin
                sum_q[s] <= sum_d[s];
                a_q[s]   <= a_d[s];
                b_q[s]   <= b_d[s];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign overflow  = ovf_q[STAGES-1];
    assign zero      = zero_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - directed and stalled-stream checks of pipelined_addsub at 4, 1 and 8 stages
module tb_pipelined_addsub;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic        cin, sub;
    logic [2:0]  in_valid_v, out_ready_v, in_ready_v, out_valid_v, cout_v, ovf_v, zero_v;
    logic [31:0] sum_v [3];

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(32), .STAGES(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .sum(sum_v[0]), .cout(cout_v[0]), .overflow(ovf_v[0]), .zero(zero_v[0]));

    pipelined_addsub #(.WIDTH(32), .STAGES(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .sum(sum_v[1]), .cout(cout_v[1]), .overflow(ovf_v[1]), .zero(zero_v[1]));

    pipelined_addsub #(.WIDTH(32), .STAGES(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .sum(sum_v[2]), .cout(cout_v[2]), .overflow(ovf_v[2]), .zero(zero_v[2]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Golden result packed as {zero, overflow, cout, sum}.
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic sb);
        logic [31:0] ye;
        logic [32:0] r;
        logic        ov;
        ye = sb ? (32'd0 - y - 32'd1) : y;
        r  = {1'b0, x} + {1'b0, ye} + {32'd0, (sb ? 1'b1 : ci)};
        ov = (x[31] == ye[31]) && (r[31] != x[31]);
        return {(r[31:0] == 32'd0), ov, r[32], r[31:0]};
    endfunction

    function automatic logic [34:0] result(input int idx);
        return {zero_v[idx], ovf_v[idx], cout_v[idx], sum_v[idx]};
    endfunction

    function automatic int stages_of(input int idx);
        return (idx == 0) ? 4 : (idx == 1) ? 1 : 8;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic single(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic ci, input logic sb, input logic [34:0] exp);
        int lat;
        out_ready_v   = 3'b111;
        a = x; b = y; cin = ci; sub = sb;
        in_valid_v[0] = 1'b1;
        tick();
        in_valid_v[0] = 1'b0;
        lat = 1;
        while (!out_valid_v[0] && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, 4);
        check({tag, " result"}, result(0), exp);
        tick();
    endtask

    task automatic run_ops(input string tag, input int idx, input int n,
                           input int stall_lo, input int stall_hi, input bit gaps);
        logic [34:0] expq[$];
        logic [31:0] ra, rb;
        logic        rc, rs;
        int          issued, got, occ, cyc, stg;
        bit          fire_in, fire_out;
        issued = 0; got = 0; occ = 0; cyc = 0;
        stg = stages_of(idx);
        ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
        while (got < n && cyc < 200) begin
            out_ready_v[idx] = !(cyc >= stall_lo && cyc <= stall_hi);
            in_valid_v[idx]  = (issued < n) && !(gaps && (cyc % 2 == 1));
            a = ra; b = rb; cin = rc; sub = rs;
            #1;
            check({tag, " in_ready"}, in_ready_v[idx], (out_ready_v[idx] || occ < stg));
            fire_in  = in_valid_v[idx] && in_ready_v[idx];
            fire_out = out_valid_v[idx] && out_ready_v[idx];
            if (fire_out) begin
                if (expq.size() == 0) begin
                    check({tag, " unexpected output"}, 1, 0);
                end else begin
                    check({tag, " result"}, result(idx), expq.pop_front());
                end
                got++;
            end
            if (fire_in) begin
                expq.push_back(model(ra, rb, rc, rs));
                issued++;
                ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
            end
            occ = occ + int'(fire_in) - int'(fire_out);
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid_v[idx]  = 1'b0;
        out_ready_v[idx] = 1'b1;
        check({tag, " results drained"}, got, n);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int stale;
        rst = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid_v = '0; out_ready_v = 3'b111;
        tick();
        tick();
        check("reset out_valid", out_valid_v[0], 0);
        check("reset flags", result(0), 0);
        check("reset in_ready", in_ready_v[0], 0);
        rst = 1'b0;
        #1;
        check("in_ready after reset", in_ready_v[0], 1);
        tick();

        single("add ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 32'h80000000});
        single("neg wrap", 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, {1'b0, 1'b1, 1'b1, 32'h7FFFFFFF});
        single("zero sum", 32'h0000FFFF, 32'hFFFF0001, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 32'h00000000});
        single("sub 5-7", 32'h00000005, 32'h00000007, 1'b1, 1'b1, {1'b0, 1'b0, 1'b0, 32'hFFFFFFFE});
        single("sub min-1", 32'h80000000, 32'h00000001, 1'b0, 1'b1, {1'b0, 1'b1, 1'b1, 32'h7FFFFFFF});
        single("add cin", 32'h00000001, 32'h00000001, 1'b1, 1'b0, {1'b0, 1'b0, 1'b0, 32'h00000003});

        run_ops("backpressure s4", 0, 8, 4, 6, 1'b0);
        run_ops("bubble s4", 0, 4, 0, 12, 1'b1);

        // Three ops in flight, then reset: nothing may survive.
        out_ready_v[0] = 1'b0;
        in_valid_v[0]  = 1'b1;
        a = 32'h11111111; b = 32'h22222222; cin = 1'b0; sub = 1'b0;
        tick();
        tick();
        tick();
        in_valid_v[0] = 1'b0;
        rst = 1'b1;
        tick();
        check("mid reset out_valid", out_valid_v[0], 0);
        check("mid reset flags", result(0), 0);
        check("mid reset in_ready", in_ready_v[0], 0);
        rst = 1'b0;
        out_ready_v[0] = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid_v[0]) stale++;
        end
        check("no stale result", stale, 0);

        do_reset();
        run_ops("backpressure s1", 1, 8, 4, 6, 1'b0);
        run_ops("backpressure s8", 2, 8, 4, 6, 1'b0);
        run_ops("bubble s8", 2, 8, 0, 20, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
